// File: rtl/pulse_tog_src.sv
// Source half of a toggle pulse synchronizer: queues events, launches one
// toggle on q per event and waits for the destination to echo it on ack.
module pulse_tog_src #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             p,
  input  logic             ack,
  input  logic             clr,
  output logic             q,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] PMAX = '1;

  logic             q_q, q_d;
  logic             a1_q, a2_q;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             idle, launch;
  logic             drop, inc, dec;

  always_comb begin
    idle   = (q_q == a2_q);
    launch = idle && (p || (pend_q != '0));
    drop   = p && !launch && (pend_q == PMAX);
    inc    = p && !launch && !drop;
    dec    = !p && launch;
    q_d    = q_q ^ launch;
    pend_d = pend_q;
    unique case (1'b1)
      inc:     pend_d = pend_q + CNT_W'(1);
      dec:     pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase
    // a dropped event outranks a clear in the same cycle
    ovf_d = drop | (ovf_q & ~clr);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= 1'b0;
      a1_q   <= 1'b0;
      a2_q   <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      a1_q   <= ack;
      a2_q   <= a1_q;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q       = q_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;
  assign busy    = (q_q != a2_q) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_tog_src.sv
// Bench for pulse_tog_src: two widths driven together, checked against an
// event-count model with an echoing destination loop.
module tb_pulse_tog_src;

  logic       c = 1'b0;
  logic       rst_n, p, clr;
  logic [1:0] ackv;
  logic       q4, busy4, ovf4;
  logic [3:0] pend4;
  logic       q2, busy2, ovf2;
  logic [1:0] pend2;

  int errors = 0;
  int checks = 0;

  always #5 c = ~c;

  pulse_tog_src #(.CNT_W(4)) u_w4 (
    .c(c), .rst_n(rst_n), .p(p), .ack(ackv[0]), .clr(clr),
    .q(q4), .busy(busy4), .pending(pend4), .ovf(ovf4)
  );

  pulse_tog_src #(.CNT_W(2)) u_w2 (
    .c(c), .rst_n(rst_n), .p(p), .ack(ackv[1]), .clr(clr),
    .q(q2), .busy(busy2), .pending(pend2), .ovf(ovf2)
  );

  // model: events accepted and launched, echo seen 1 and 2 edges ago
  int        acc [2];
  int        sent[2];
  bit        movf[2];
  bit        seen1[2];
  bit        seen2[2];
  bit [31:0] qsh [2];
  int        mode;
  int        dly;

  function automatic int maxv(input int k);
    return (k == 0) ? 15 : 3;
  endfunction

  function automatic bit mq(input int k);
    return sent[k][0];
  endfunction

  function automatic int mpend(input int k);
    return acc[k] - sent[k];
  endfunction

  function automatic bit mbusy(input int k);
    return (mq(k) != seen2[k]) || (mpend(k) != 0);
  endfunction

  function automatic bit midle(input int k);
    return mq(k) == seen2[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      acc[k]   = 0;
      sent[k]  = 0;
      movf[k]  = 1'b0;
      seen1[k] = 1'b0;
      seen2[k] = 1'b0;
      qsh[k]   = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit lch;
      bit dropped;
      if (!rst_n) begin
        acc[k] = 0; sent[k] = 0; movf[k] = 1'b0;
        seen1[k] = 1'b0; seen2[k] = 1'b0;
      end else begin
        lch = midle(k) && (mpend(k) > 0 || p);
        dropped = 1'b0;
        if (p) begin
          if (mpend(k) + 1 - int'(lch) > maxv(k)) dropped = 1'b1;
          else acc[k]++;
        end
        if (lch) sent[k]++;
        movf[k]  = dropped | (movf[k] & ~clr);
        seen2[k] = seen1[k];
        seen1[k] = ackv[k];
      end
      qsh[k] = {qsh[k][30:0], mq(k)};
    end
  endtask

  task automatic ack_update();
    for (int k = 0; k < 2; k++) begin
      case (mode)
        1:       ackv[k] = qsh[k][dly];
        2:       ackv[k] = ~ackv[k];
        default: ackv[k] = ackv[k];
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("w4.q",    8'(q4),    8'(mq(0)));
    chk("w4.busy", 8'(busy4), 8'(mbusy(0)));
    chk("w4.pend", 8'(pend4), 8'(mpend(0)));
    chk("w4.ovf",  8'(ovf4),  8'(movf[0]));
    chk("w2.q",    8'(q2),    8'(mq(1)));
    chk("w2.busy", 8'(busy2), 8'(mbusy(1)));
    chk("w2.pend", 8'(pend2), 8'(mpend(1)));
    chk("w2.ovf",  8'(ovf2),  8'(movf[1]));
  endtask

  task automatic cyc();
    @(posedge c);
    model_edge();
    #1;
    ack_update();
    @(negedge c);
    compare_all();
  endtask

  initial begin
    int  last;
    int  n;
    bit  prevq;
    bit  found;

    rst_n = 1'b0; p = 1'b0; clr = 1'b0; ackv = 2'b00;
    mode = 2; dly = 3;
    model_reset();

    // reset held with p high and ack toggling
    p = 1'b1;
    repeat (4) cyc();
    chk("rst.q", 8'(q4), 8'd0);
    chk("rst.busy", 8'(busy4), 8'd0);
    p = 1'b0; ackv = 2'b00; mode = 1; dly = 3;
    rst_n = 1'b1;
    repeat (2) cyc();

    // single event, 3-cycle echo
    p = 1'b1;
    cyc();
    p = 1'b0;
    chk("single.q", 8'(q4), 8'd1);
    chk("single.busy", 8'(busy4), 8'd1);
    repeat (4) cyc();
    chk("single.busy_hold", 8'(busy4), 8'd1);
    cyc();
    chk("single.busy_done", 8'(busy4), 8'd0);
    repeat (3) cyc();
    chk("single.one_toggle", 8'(q4), 8'd1);

    // burst with ack held, then close the loop
    mode = 0;
    p = 1'b1;
    repeat (5) cyc();
    p = 1'b0;
    chk("burst.pend", 8'(pend4), 8'd4);
    chk("burst.q", 8'(q4), 8'd0);
    mode = 1; dly = 3;
    last = -1; n = 0; prevq = q4;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (q4 !== prevq) begin
        if (last >= 0) chk("burst.gap", 8'(i - last), 8'd6);
        last = i; n++; prevq = q4;
      end
    end
    chk("burst.toggles", 8'(n), 8'd4);
    chk("burst.idle", 8'(busy4), 8'd0);

    // overflow on the 2-bit instance
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    mode = 0;
    p = 1'b1;
    repeat (5) cyc();
    p = 1'b0;
    chk("ovf.pend", 8'(pend2), 8'd3);
    chk("ovf.set", 8'(ovf2), 8'd1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf.clr", 8'(ovf2), 8'd0);
    clr = 1'b1; p = 1'b1;
    cyc();
    clr = 1'b0; p = 1'b0;
    chk("ovf.set_wins", 8'(ovf2), 8'd1);
    mode = 1; dly = 2;
    for (int i = 0; i < 120 && (mbusy(0) || mbusy(1)); i++) cyc();
    chk("drain.busy", 8'(busy4), 8'd0);

    // event arriving on the launch edge with events queued
    mode = 0;
    p = 1'b1;
    repeat (3) cyc();
    p = 1'b0;
    chk("simul.pend_pre", 8'(pend4), 8'd2);
    mode = 1; dly = 4;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      found = midle(0);
    end
    chk("simul.reached_idle", 8'(found), 8'd1);
    prevq = q4;
    p = 1'b1;
    cyc();
    p = 1'b0;
    chk("simul.pend", 8'(pend4), 8'd2);
    chk("simul.toggle", 8'(q4 ^ prevq), 8'd1);

    // reset between edges while waiting
    mode = 0;
    cyc();
    chk("mid.busy_pre", 8'(busy4), 8'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("mid.pend", 8'(pend4), 8'd0);
    ackv = 2'b00;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("mid.no_toggle4", 8'(q4), 8'd0);
    chk("mid.no_toggle2", 8'(q2), 8'd0);

    // random traffic with varying echo delay
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) dly = int'($urandom_range(0, 4));
      p   = ($urandom_range(0, 99) < 40);
      clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    p = 1'b0; clr = 1'b0;
    for (int i = 0; i < 200 && (mbusy(0) || mbusy(1)); i++) cyc();
    chk("final.busy4", 8'(busy4), 8'd0);
    chk("final.busy2", 8'(busy2), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_tog_src.md
# pulse_tog_src

Source-side event launcher for the toggle-based pulse synchronizer. Accepts single-cycle event pulses in its own clock domain, queues them in a saturating counter and emits one level toggle per event on `q`. It launches a new toggle only after the destination domain has returned the previous one on `ack`. Its `q` drives the destination's pulse-regenerating synchronizer directly, and that synchronizer's delayed toggle output is wired back to `ack`. The result is a lossless, rate-limited event crossing.

## Interface
- `CNT_W`, default 4: width of the pending-event counter; the counter saturates at 2^CNT_W-1.
- `c`  in  1: source-domain clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronized externally to `c`.
- `p`  in  1: event pulse. Each cycle sampled high is one event.
- `ack`  in  1: returned toggle from the destination domain. Asynchronous to `c`.
- `clr`  in  1: synchronous clear of `ovf`.
- `q`  out  1: toggle level sent to the destination.
- `busy`  out  1: high while a toggle is unacknowledged or events are pending.
- `pending`  out  CNT_W: number of queued events not yet launched.
- `ovf`  out  1: sticky flag, set when an event was dropped.

## Operation
- `ack` passes through an internal 2-flop synchronizer, `a1` → `a2`. Both flops reset to 0.
- Handshake states:
  - IDLE: `q == a2`.
  - WAIT: `q != a2`.
  - No explicit state register; the state is derived from `q` and `a2`.
- Launch: `launch = IDLE && (pending != 0 || p)`. On launch, `q` toggles at the next edge.
- Counter update: `pending_next = pending + p - launch`.
  - Both `p` and launch in the same cycle: `pending` is unchanged.
  - `p` with `pending == 0` in IDLE: the event bypasses the queue, `pending` stays 0, `q` toggles.
- Saturation: `p` && !launch && `pending == 2^CNT_W-1` → `pending` holds and `ovf` sets to 1. The event is lost.
- `ovf`:
  - Cleared by `clr`.
  - If a set and `clr` occur in the same cycle, set wins and `ovf` stays 1.
- `busy = (q != a2) || (pending != 0)`. Combinational from registers; no path from `p`.
- Reset values: `q`=0, `a1`=`a2`=0, `pending`=0, `ovf`=0, `busy`=0.
- Reset mid-operation: queued and in-flight events are discarded. Source and destination are reset together. A source-only reset is unsupported, because it produces a spurious destination pulse when `q` returns from 1 to 0.
- `ack` toggling without a preceding `q` toggle is a protocol error. The block does not detect it; the state simply follows the `q`/`a2` comparison.

## Timing
- `p` high at edge N, IDLE, `pending == 0` → `q` toggles at edge N+1.
- `ack` change before edge M → `a2` reflects it at edge M+1 → the next launch can toggle `q` at edge M+2.
- Events with `ack = q` delayed by D source cycles: sustained throughput is one event per D+3 cycles.
- `pending` and `ovf` update at the same edge that samples `p`.
- `busy` deasserts at the edge where `a2` catches up with `q` and `pending == 0`.

## Test plan
- Reset: hold `rst_n`=0 with `p`=1 and `ack` toggling → `q`=0, `busy`=0, `pending`=0, `ovf`=0 throughout.
- Single event, `ack` = `q` delayed 3 cycles: one-cycle `p` at edge 10 gives:
  - `q` 0→1 at edge 11;
  - `busy`=1 from edge 11 until `a2`=1 at edge 16;
  - exactly one toggle.
- Burst with `ack` held: 5 consecutive `p` cycles → `q` toggles once and `pending` ends at 4. Then close the 3-cycle `ack` loop → 4 further toggles spaced 6 cycles apart, `pending` counts 3,2,1,0, then `busy`=0.
- Overflow, `CNT_W`=2, `ack` stuck: 5 `p` pulses → `pending`=3, `ovf`=1 after the 5th pulse. Pulse `clr` → `ovf`=0. Then assert `clr` and an overflowing `p` in the same cycle → `ovf`=1.
- Simultaneous events: `pending`=2 in IDLE and `p`=1 at the launch edge → `pending` stays 2 and `q` toggles.
- Mid-operation reset: `pending`=2 in WAIT, then assert `rst_n`=0 between clock edges → all outputs 0 immediately. After release with `p`=0 and `ack`=0, no further toggles occur.
